// File: rtl/output_mem_arbiter_if.sv
// Request/grant/return bundle between the three output-memory requesters,
// the arbiter and the single-port output SRAM.
interface output_mem_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 32
);
  logic          eng_wr_req;
  logic [AW-1:0] eng_wr_addr;
  logic [DW-1:0] eng_wr_data;
  logic          eng_wr_gnt;
  logic          fb_rd_req;
  logic [AW-1:0] fb_rd_addr;
  logic          fb_rd_gnt;
  logic          fb_rd_valid;
  logic [DW-1:0] fb_rd_data;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic          cpu_rd_gnt;
  logic          cpu_rd_valid;
  logic [DW-1:0] cpu_rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          quiesce_req;
  logic          quiesce_ack;

  modport slave (
    input  eng_wr_req, eng_wr_addr, eng_wr_data,
    input  fb_rd_req, fb_rd_addr, cpu_rd_req, cpu_rd_addr,
    input  mem_rdata, quiesce_req,
    output eng_wr_gnt, fb_rd_gnt, fb_rd_valid, fb_rd_data,
    output cpu_rd_gnt, cpu_rd_valid, cpu_rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata, quiesce_ack
  );

  modport master (
    output eng_wr_req, eng_wr_addr, eng_wr_data,
    output fb_rd_req, fb_rd_addr, cpu_rd_req, cpu_rd_addr,
    output mem_rdata, quiesce_req,
    input  eng_wr_gnt, fb_rd_gnt, fb_rd_valid, fb_rd_data,
    input  cpu_rd_gnt, cpu_rd_valid, cpu_rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, quiesce_ack
  );
endinterface

// File: rtl/output_mem_arbiter.sv
// Single-cycle arbiter sharing one output-memory SRAM port between engine
// write-back, feedback read and CPU readback, with CPU anti-starvation and quiesce.
module output_mem_arbiter #(
  parameter int AW           = 19,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output_mem_arbiter_if.slave   bus
);
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_FB, TAG_CPU} tag_t;

  state_t        r_state, w_state_nxt;
  tag_t          r_tag, w_tag_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ack;
  logic          w_boost, w_run;
  logic          w_eng_gnt, w_fb_gnt, w_cpu_gnt;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  assign w_boost = (r_cnt == LIMIT);
  // Grants are suppressed during reset and in the cycle quiesce is first seen.
  assign w_run   = rst_n && (r_state == RUN) && !bus.quiesce_req;

  always_comb begin
    w_eng_gnt = 1'b0;
    w_fb_gnt  = 1'b0;
    w_cpu_gnt = 1'b0;
    if (w_run) begin
      if (w_boost && bus.cpu_rd_req) w_cpu_gnt = 1'b1;
      else if (bus.eng_wr_req)       w_eng_gnt = 1'b1;
      else if (bus.fb_rd_req)        w_fb_gnt  = 1'b1;
      else if (bus.cpu_rd_req)       w_cpu_gnt = 1'b1;
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    if (w_eng_gnt) begin
      w_addr  = bus.eng_wr_addr;
      w_wdata = bus.eng_wr_data;
    end else if (w_fb_gnt) begin
      w_addr  = bus.fb_rd_addr;
    end else if (w_cpu_gnt) begin
      w_addr  = bus.cpu_rd_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tag_nxt   = TAG_NONE;
    if (w_fb_gnt)       w_tag_nxt = TAG_FB;
    else if (w_cpu_gnt) w_tag_nxt = TAG_CPU;
    unique case (r_state)
      RUN: begin
        if (bus.quiesce_req) w_state_nxt = DRAIN;
        if (bus.cpu_rd_req && !w_cpu_gnt) begin
          if (r_cnt != LIMIT) w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      DRAIN:    if (r_tag == TAG_NONE) w_state_nxt = QUIESCED;
      QUIESCED: if (!bus.quiesce_req)  w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_tag   <= TAG_NONE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= (w_state_nxt == QUIESCED);
    end
  end

  assign bus.eng_wr_gnt   = w_eng_gnt;
  assign bus.fb_rd_gnt    = w_fb_gnt;
  assign bus.cpu_rd_gnt   = w_cpu_gnt;
  assign bus.mem_en       = w_eng_gnt | w_fb_gnt | w_cpu_gnt;
  assign bus.mem_we       = w_eng_gnt;
  assign bus.mem_addr     = w_addr;
  assign bus.mem_wdata    = w_wdata;
  assign bus.fb_rd_valid  = (r_tag == TAG_FB);
  assign bus.cpu_rd_valid = (r_tag == TAG_CPU);
  assign bus.fb_rd_data   = bus.mem_rdata;
  assign bus.cpu_rd_data  = bus.mem_rdata;
  assign bus.quiesce_ack  = r_ack;
endmodule

// File: tb/tb_output_mem_arbiter.sv
// Directed bench for output_mem_arbiter: SRAM model, per-cycle behavioural
// reference model and hand-computed expectations for each scenario.
module tb_output_mem_arbiter;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  output_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(int a);
    return 32'hC0DE0000 ^ a;
  endfunction

  // SRAM: one-cycle read latency, unwritten words hold init_word(addr)
  logic [DW-1:0] sram [int];
  logic [DW-1:0] sram_rdata = '0;
  assign bus.mem_rdata = sram_rdata;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[int'(bus.mem_addr)] = bus.mem_wdata;
      else sram_rdata <= sram.exists(int'(bus.mem_addr)) ?
                         sram[int'(bus.mem_addr)] : init_word(int'(bus.mem_addr));
    end
  end

  // Reference model: mode 0=running 1=draining 2=quiesced; ret 0=none 1=fb 2=cpu
  int            m_mode = 0;
  int            m_starve = 0;
  int            m_ret = 0;
  logic [DW-1:0] m_ret_data = '0;
  logic [DW-1:0] shadow [int];

  function automatic logic [DW-1:0] peek(int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    int win;
    logic [AW-1:0] ea;
    if (!rst_n) begin
      chk("rst_gnts", {bus.eng_wr_gnt, bus.fb_rd_gnt, bus.cpu_rd_gnt}, 0);
      chk("rst_mem", {bus.mem_en, bus.mem_we}, 0);
      chk("rst_vld", {bus.fb_rd_valid, bus.cpu_rd_valid}, 0);
      chk("rst_ack", bus.quiesce_ack, 0);
      m_mode = 0; m_starve = 0; m_ret = 0;
    end else begin
      win = 0;
      if (m_mode == 0 && !bus.quiesce_req) begin
        if (m_starve == SL && bus.cpu_rd_req) win = 3;
        else if (bus.eng_wr_req)              win = 1;
        else if (bus.fb_rd_req)               win = 2;
        else if (bus.cpu_rd_req)              win = 3;
      end
      ea = (win == 1) ? bus.eng_wr_addr : (win == 2) ? bus.fb_rd_addr :
           (win == 3) ? bus.cpu_rd_addr : '0;
      chk("m_gnts", {bus.eng_wr_gnt, bus.fb_rd_gnt, bus.cpu_rd_gnt},
          {win == 1, win == 2, win == 3});
      chk("m_mem_en", bus.mem_en, win != 0);
      chk("m_mem_we", bus.mem_we, win == 1);
      chk("m_mem_addr", bus.mem_addr, ea);
      chk("m_mem_wdata", bus.mem_wdata, (win == 1) ? bus.eng_wr_data : '0);
      chk("m_vld", {bus.fb_rd_valid, bus.cpu_rd_valid}, {m_ret == 1, m_ret == 2});
      if (m_ret == 1) chk("m_fb_data", bus.fb_rd_data, m_ret_data);
      if (m_ret == 2) chk("m_cpu_data", bus.cpu_rd_data, m_ret_data);
      chk("m_ack", bus.quiesce_ack, m_mode == 2);
      if (m_mode == 0)
        m_starve = (bus.cpu_rd_req && win != 3) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
      case (m_mode)
        0: if (bus.quiesce_req) m_mode = 1;
        1: if (m_ret == 0) m_mode = 2;
        default: if (!bus.quiesce_req) m_mode = 0;
      endcase
      if (win == 1) shadow[int'(ea)] = bus.eng_wr_data;
      m_ret = (win == 2) ? 1 : (win == 3) ? 2 : 0;
      if (win >= 2) m_ret_data = peek(int'(ea));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.eng_wr_req = 1'b0; bus.eng_wr_addr = '0; bus.eng_wr_data = '0;
    bus.fb_rd_req = 1'b0;  bus.fb_rd_addr = '0;
    bus.cpu_rd_req = 1'b0; bus.cpu_rd_addr = '0;
    bus.quiesce_req = 1'b0;
  endtask

  int nf = 0;
  int nc = 0;

  initial begin
    idle();
    // Reset with every requester active
    bus.eng_wr_req = 1'b1; bus.eng_wr_addr = 19'd1; bus.eng_wr_data = 32'hAAAA0001;
    bus.fb_rd_req = 1'b1;  bus.fb_rd_addr = 19'd2;
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 19'd3;
    repeat (2) step();
    chk("reset_gnts", {bus.eng_wr_gnt, bus.fb_rd_gnt, bus.cpu_rd_gnt}, 3'b000);
    chk("reset_mem_en", bus.mem_en, 1'b0);
    chk("reset_vld", {bus.fb_rd_valid, bus.cpu_rd_valid}, 2'b00);
    step(); rst_n = 1'b1; #1;
    chk("release_eng_gnt", bus.eng_wr_gnt, 1'b1);
    step(); bus.eng_wr_req = 1'b0; #1;
    chk("release_fb_next", bus.fb_rd_gnt, 1'b1);
    step(); bus.fb_rd_req = 1'b0; #1;
    chk("release_cpu_last", bus.cpu_rd_gnt, 1'b1);
    step(); bus.cpu_rd_req = 1'b0;

    // Priority: eng > fb > cpu
    step();
    bus.eng_wr_req = 1'b1; bus.eng_wr_addr = 19'd5; bus.eng_wr_data = 32'h12345678;
    bus.fb_rd_req = 1'b1;  bus.fb_rd_addr = 19'd6;
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 19'd7;
    #1;
    chk("prio_eng_gnt", {bus.eng_wr_gnt, bus.fb_rd_gnt, bus.cpu_rd_gnt}, 3'b100);
    chk("prio_we_addr", {bus.mem_we, 13'd0, bus.mem_addr}, {1'b1, 13'd0, 19'd5});
    step(); bus.eng_wr_req = 1'b0; #1;
    chk("prio_fb_gnt", {bus.eng_wr_gnt, bus.fb_rd_gnt, bus.cpu_rd_gnt}, 3'b010);
    chk("prio_fb_addr", bus.mem_addr, 19'd6);
    step(); bus.fb_rd_req = 1'b0; #1;
    chk("prio_fb_vld", bus.fb_rd_valid, 1'b1);
    chk("prio_fb_data", bus.fb_rd_data, 32'hC0DE0006);
    chk("prio_cpu_gnt", bus.cpu_rd_gnt, 1'b1);
    step(); bus.cpu_rd_req = 1'b0; #1;
    chk("prio_cpu_data", {bus.cpu_rd_valid, bus.cpu_rd_data}, {1'b1, 32'hC0DE0007});

    // Read-after-write
    step(); bus.eng_wr_req = 1'b1; bus.eng_wr_addr = 19'd100; bus.eng_wr_data = 32'hDEADBEEF; #1;
    chk("raw_wr_gnt", bus.eng_wr_gnt, 1'b1);
    step(); bus.eng_wr_req = 1'b0; bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 19'd100; #1;
    chk("raw_rd_gnt", bus.cpu_rd_gnt, 1'b1);
    step(); bus.cpu_rd_req = 1'b0; #1;
    chk("raw_rd_data", {bus.cpu_rd_valid, bus.cpu_rd_data}, {1'b1, 32'hDEADBEEF});

    // Starvation: eng hogs the port, CPU boosted on its 9th requesting cycle
    step();
    bus.eng_wr_req = 1'b1; bus.eng_wr_addr = 19'd200; bus.eng_wr_data = 32'h00000005;
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 19'd7;
    #1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) step();
      if (i < 9) chk("starve_eng", {bus.eng_wr_gnt, bus.cpu_rd_gnt}, 2'b10);
      else       chk("starve_boost", {bus.eng_wr_gnt, bus.cpu_rd_gnt}, 2'b01);
    end
    step(); bus.cpu_rd_req = 1'b0; #1;
    chk("starve_eng_resume", bus.eng_wr_gnt, 1'b1);
    chk("starve_cpu_data", {bus.cpu_rd_valid, bus.cpu_rd_data}, {1'b1, 32'hC0DE0007});
    step(); bus.eng_wr_req = 1'b0;

    // Quiesce with a feedback read in flight
    step(); bus.fb_rd_req = 1'b1; bus.fb_rd_addr = 19'd6; #1;
    chk("q_fb_gnt", bus.fb_rd_gnt, 1'b1);
    step();
    bus.fb_rd_req = 1'b0; bus.quiesce_req = 1'b1;
    bus.eng_wr_req = 1'b1; bus.eng_wr_addr = 19'd300; bus.eng_wr_data = 32'h00000077;
    #1;
    chk("q_fb_vld", bus.fb_rd_valid, 1'b1);
    chk("q_no_gnt_n1", {bus.eng_wr_gnt, bus.mem_en}, 2'b00);
    step();
    chk("q_drain", {bus.eng_wr_gnt, bus.quiesce_ack}, 2'b00);
    step();
    chk("q_ack_n3", {bus.eng_wr_gnt, bus.quiesce_ack}, 2'b01);
    step(); bus.quiesce_req = 1'b0; #1;
    chk("q_ack_hold", {bus.eng_wr_gnt, bus.quiesce_ack}, 2'b01);
    step();
    chk("q_resume", {bus.eng_wr_gnt, bus.quiesce_ack}, 2'b10);
    step(); bus.eng_wr_req = 1'b0;

    // Alternating fb / cpu reads
    for (int i = 0; i <= 10; i++) begin
      step();
      bus.fb_rd_req  = (i < 10) && (i % 2 == 0);
      bus.cpu_rd_req = (i < 10) && (i % 2 == 1);
      bus.fb_rd_addr  = AW'(400 + i);
      bus.cpu_rd_addr = AW'(400 + i);
      #1;
      if (i < 10)
        chk("alt_gnt", {bus.fb_rd_gnt, bus.cpu_rd_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) begin
        chk("alt_vld", {bus.fb_rd_valid, bus.cpu_rd_valid}, (i % 2 == 1) ? 2'b10 : 2'b01);
        nf += int'(bus.fb_rd_valid);
        nc += int'(bus.cpu_rd_valid);
      end
    end
    chk("alt_total", 64'(nf + nc), 64'd10);
    chk("alt_fb_count", 64'(nf), 64'd5);

    // Reset while a CPU read is in flight
    step(); bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 19'd9; #1;
    chk("rstmid_gnt", bus.cpu_rd_gnt, 1'b1);
    step(); bus.cpu_rd_req = 1'b0; rst_n = 1'b0; #1;
    chk("rstmid_drop", bus.cpu_rd_valid, 1'b0);
    step(); rst_n = 1'b1; #1;
    chk("rstmid_rel", {bus.fb_rd_valid, bus.cpu_rd_valid}, 2'b00);
    step();
    chk("rstmid_after", {bus.fb_rd_valid, bus.cpu_rd_valid}, 2'b00);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
